// File: rtl/truthtable_pkg.sv
// Shared widths and helpers for the truth-table stream packer.
// Optional TLAST support is enabled with TRUTHTABLE_PACKER_TLAST_EN.
package truthtable_pkg;

   localparam int unsigned TT_IN_WIDTH    = 16;
   localparam int unsigned PACK_WIDTH_MAX = 32;

   typedef logic [TT_IN_WIDTH-1:0] tt_vec_t;

   // Bit-index width for a packer of the given word width (at least 1 bit).
   function automatic int unsigned idx_width(input int unsigned pack_width);
      return (pack_width <= 2) ? 1 : $clog2(pack_width);
   endfunction

endpackage

// File: rtl/truthtable_result_packer.sv
// Packs result bits LSB first into PACK_WIDTH-bit words behind a one-word output register.
// With TRUTHTABLE_PACKER_TLAST_EN, a last flag flushes the partial word and tags it.
module truthtable_result_packer
   import truthtable_pkg::*;
#(
   parameter int unsigned PACK_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  bit_valid_i,
   input  logic                  bit_i,
`ifdef TRUTHTABLE_PACKER_TLAST_EN
   input  logic                  last_i,
   output logic                  out_last_o,
`endif
   output logic                  adv_o,
   output logic [PACK_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i
);

   localparam int unsigned IW = idx_width(PACK_WIDTH);

   logic [IW-1:0]         idx_q, idx_d;
   logic [PACK_WIDTH-1:0] pack_q, pack_d;
   logic [PACK_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  complete;
`ifdef TRUTHTABLE_PACKER_TLAST_EN
   logic                  out_last_q, out_last_d;
`endif

   always_comb begin
`ifdef TRUTHTABLE_PACKER_TLAST_EN
      complete = (idx_q == IW'(PACK_WIDTH - 1)) | last_i;
`else
      complete = (idx_q == IW'(PACK_WIDTH - 1));
`endif
      // A completing bit may only advance if the output slot is free or draining now.
      adv_o       = bit_valid_i & (~complete | ~out_valid_q | out_ready_i);
      idx_d       = idx_q;
      pack_d      = pack_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q & ~out_ready_i;
`ifdef TRUTHTABLE_PACKER_TLAST_EN
      out_last_d  = out_last_q;
`endif
      if (adv_o) begin
         if (complete) begin
            out_data_d  = pack_q | (PACK_WIDTH'(bit_i) << idx_q);
            out_valid_d = 1'b1;
            pack_d      = '0;
            idx_d       = '0;
`ifdef TRUTHTABLE_PACKER_TLAST_EN
            out_last_d  = last_i;
`endif
         end else begin
            pack_d[idx_q] = bit_i;
            idx_d         = idx_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q       <= '0;
         pack_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
`ifdef TRUTHTABLE_PACKER_TLAST_EN
         out_last_q  <= 1'b0;
`endif
      end else begin
         idx_q       <= idx_d;
         pack_q      <= pack_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
`ifdef TRUTHTABLE_PACKER_TLAST_EN
         out_last_q  <= out_last_d;
`endif
      end
   end

   always_comb begin
      out_data_o  = out_data_q;
      out_valid_o = out_valid_q;
`ifdef TRUTHTABLE_PACKER_TLAST_EN
      out_last_o  = out_last_q;
`endif
   end

endmodule

// File: rtl/wrapper_truthtable.sv
// Combinational truth table: one result bit per 16-bit input vector (odd parity).
module wrapper_truthtable
   import truthtable_pkg::*;
(
   input  logic [TT_IN_WIDTH-1:0] input_data,
   output logic                   result_data
);

   always_comb begin
      result_data = ^input_data;
   end

endmodule

// File: rtl/truthtable_stream_packer.sv
// Stream front-end: registers 16-bit vectors onto the truth table and packs results into words.
// Optional in_TLAST/out_TLAST ports are enabled with TRUTHTABLE_PACKER_TLAST_EN.
module truthtable_stream_packer
   import truthtable_pkg::*;
#(
   parameter int unsigned PACK_WIDTH = 8
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   input  logic [TT_IN_WIDTH-1:0] in_TDATA,
   input  logic                   in_TVALID,
   output logic                   in_TREADY,
`ifdef TRUTHTABLE_PACKER_TLAST_EN
   input  logic                   in_TLAST,
   output logic                   out_TLAST,
`endif
   output logic [PACK_WIDTH-1:0]  out_TDATA,
   output logic                   out_TVALID,
   input  logic                   out_TREADY
);

   tt_vec_t in_reg_q, in_reg_d;
   logic    in_reg_valid_q, in_reg_valid_d;
   logic    in_hs;
   logic    adv;
   logic    result;
`ifdef TRUTHTABLE_PACKER_TLAST_EN
   logic    last_reg_q, last_reg_d;
`endif

   // Ready is held low through reset so nothing is accepted while state is cleared.
   always_comb begin
      in_TREADY      = ~ap_rst & (~in_reg_valid_q | adv);
      in_hs          = in_TVALID & in_TREADY;
      in_reg_d       = in_hs ? in_TDATA : in_reg_q;
      in_reg_valid_d = in_hs | (in_reg_valid_q & ~adv);
`ifdef TRUTHTABLE_PACKER_TLAST_EN
      last_reg_d     = in_hs ? in_TLAST : last_reg_q;
`endif
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         in_reg_q       <= '0;
         in_reg_valid_q <= 1'b0;
`ifdef TRUTHTABLE_PACKER_TLAST_EN
         last_reg_q     <= 1'b0;
`endif
      end else begin
         in_reg_q       <= in_reg_d;
         in_reg_valid_q <= in_reg_valid_d;
`ifdef TRUTHTABLE_PACKER_TLAST_EN
         last_reg_q     <= last_reg_d;
`endif
      end
   end

   wrapper_truthtable u_table (
      .input_data  (in_reg_q),
      .result_data (result)
   );

   truthtable_result_packer #(
      .PACK_WIDTH (PACK_WIDTH)
   ) u_packer (
      .clk_i       (ap_clk),
      .rst_i       (ap_rst),
      .bit_valid_i (in_reg_valid_q),
      .bit_i       (result),
`ifdef TRUTHTABLE_PACKER_TLAST_EN
      .last_i      (last_reg_q),
      .out_last_o  (out_TLAST),
`endif
      .adv_o       (adv),
      .out_data_o  (out_TDATA),
      .out_valid_o (out_TVALID),
      .out_ready_i (out_TREADY)
   );

endmodule

// File: tb/tb_truthtable_stream_packer.sv
// Directed and random bench for truthtable_stream_packer with a parity-table scoreboard.
module tb_truthtable_stream_packer;

   localparam int unsigned PW = 8;

   logic          ap_clk     = 1'b0;
   logic          ap_rst     = 1'b1;
   logic [15:0]   in_TDATA   = '0;
   logic          in_TVALID  = 1'b0;
   logic          in_TREADY;
   logic          in_TLAST   = 1'b0;
   logic [PW-1:0] out_TDATA;
   logic          out_TVALID;
   logic          out_TREADY = 1'b1;
   logic          out_TLAST;

   int unsigned   total = 0;
   int unsigned   bad   = 0;

   always #5 ap_clk = ~ap_clk;

   truthtable_stream_packer #(
      .PACK_WIDTH (PW)
   ) dut (
      .ap_clk     (ap_clk),
      .ap_rst     (ap_rst),
      .in_TDATA   (in_TDATA),
      .in_TVALID  (in_TVALID),
      .in_TREADY  (in_TREADY),
`ifdef TRUTHTABLE_PACKER_TLAST_EN
      .in_TLAST   (in_TLAST),
      .out_TLAST  (out_TLAST),
`endif
      .out_TDATA  (out_TDATA),
      .out_TVALID (out_TVALID),
      .out_TREADY (out_TREADY)
   );

`ifndef TRUTHTABLE_PACKER_TLAST_EN
   assign out_TLAST = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Table model: result is 1 when the vector has an odd number of ones.
   function automatic logic tt_model(input logic [15:0] v);
      int unsigned ones = 0;
      for (int i = 0; i < 16; i++) if (v[i]) ones++;
      return (ones % 2) == 1;
   endfunction

   // Scoreboard: build expected words from accepted vectors, compare every output handshake.
   logic [PW:0]   exp_q[$];
   int unsigned   word_cyc_q[$];
   logic [PW-1:0] acc_bits = '0;
   int unsigned   nbits = 0;
   int unsigned   words = 0;
   int unsigned   cyc   = 0;
   logic [PW:0]   last_obs = '0;
   logic          hold_v = 1'b0;
   logic [PW:0]   hold_d = '0;

   initial forever begin
      logic [PW:0] obs;
      @(posedge ap_clk);
      cyc++;
      obs = {out_TLAST, out_TDATA};
      if (ap_rst) begin
         acc_bits = '0;
         nbits    = 0;
         exp_q.delete();
         hold_v   = 1'b0;
      end else begin
         if (hold_v) check("hold_stable", 32'(obs), 32'(hold_d));
         hold_v = out_TVALID && !out_TREADY;
         hold_d = obs;
         if (out_TVALID && out_TREADY) begin
            words++;
            last_obs = obs;
            word_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) check("word_unexpected", 32'(obs), 'x);
            else check("word", 32'(obs), 32'(exp_q.pop_front()));
         end
         if (in_TVALID && in_TREADY) begin
            acc_bits[nbits] = tt_model(in_TDATA);
            nbits++;
            if (nbits == PW || in_TLAST) begin
               exp_q.push_back({in_TLAST, acc_bits});
               acc_bits = '0;
               nbits    = 0;
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic push(input logic [15:0] d, input logic last, output int unsigned waits);
      waits     = 0;
      in_TDATA  = d;
      in_TLAST  = last;
      in_TVALID = 1'b1;
      #1;
      while (!in_TREADY && waits < 200) begin
         @(negedge ap_clk);
         #1;
         waits++;
      end
      if (!in_TREADY) check("push_timeout", 32'(in_TREADY), 32'd1);
      @(negedge ap_clk);
      in_TLAST = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [15:0] dir [8];
   logic        rnd_done = 1'b0;

   initial begin
      int unsigned w, w0, stalls, acc_cnt;
      dir = '{16'h0001, 16'h0000, 16'h0007, 16'h8000, 16'h0003, 16'h00FF, 16'hFFFF, 16'h1000};

      // Reset state
      repeat (2) @(negedge ap_clk);
      check("rst_tready", 32'(in_TREADY), 32'd0);
      check("rst_tvalid", 32'(out_TVALID), 32'd0);
      check("rst_tdata", 32'(out_TDATA), 32'd0);
      ap_rst = 1'b0;
      #1;
      check("tready_after_rst", 32'(in_TREADY), 32'd1);
      @(negedge ap_clk);

      // Directed word 0x8D, latency and single-cycle valid
      w0 = words;
      for (int i = 0; i < 8; i++) push(dir[i], 1'b0, w);
      in_TVALID = 1'b0;
      check("lat_edge_k", 32'(out_TVALID), 32'd0);
      @(negedge ap_clk);
      check("lat_edge_k1", 32'(out_TVALID), 32'd1);
      check("dir_data", 32'(out_TDATA), 32'h8D);
      @(negedge ap_clk);
      check("dir_one_cycle", 32'(out_TVALID), 32'd0);
      check("dir_words", words - w0, 32'd1);

      // Backpressure: 16 vectors fit, then ready drops
      out_TREADY = 1'b0;
      w0 = words;
      acc_cnt = 0;
      in_TVALID = 1'b1;
      for (int c = 0; c < 30; c++) begin
         in_TDATA = 16'($urandom);
         #1;
         if (in_TREADY) acc_cnt++;
         @(negedge ap_clk);
      end
      #1;
      check("bp_accepted", acc_cnt, 32'd16);
      check("bp_tready_low", 32'(in_TREADY), 32'd0);
      check("bp_no_output", words - w0, 32'd0);
      @(negedge ap_clk);
      in_TVALID  = 1'b0;
      out_TREADY = 1'b1;
      repeat (4) @(negedge ap_clk);
      check("bp_words", words - w0, 32'd2);
      check("bp_pending", exp_q.size(), 32'd0);

      // Sustained streaming
      w0 = words;
      stalls = 0;
      word_cyc_q.delete();
      for (int i = 0; i < 64; i++) begin
         push(16'($urandom), 1'b0, w);
         stalls += w;
      end
      in_TVALID = 1'b0;
      repeat (3) @(negedge ap_clk);
      check("st_stalls", stalls, 32'd0);
      check("st_words", words - w0, 32'd8);
      for (int i = 1; i < 8; i++)
         if (word_cyc_q.size() > i) check("st_gap", word_cyc_q[i] - word_cyc_q[i-1], 32'd8);

      // Reset mid-word
      for (int i = 0; i < 5; i++) push(16'($urandom), 1'b0, w);
      in_TVALID = 1'b0;
      ap_rst = 1'b1;
      @(negedge ap_clk);
      check("mr_tready", 32'(in_TREADY), 32'd0);
      check("mr_tvalid", 32'(out_TVALID), 32'd0);
      check("mr_tdata", 32'(out_TDATA), 32'd0);
      ap_rst = 1'b0;
      w0 = words;
      for (int i = 0; i < 8; i++) push(dir[i], 1'b0, w);
      in_TVALID = 1'b0;
      repeat (3) @(negedge ap_clk);
      check("mr_words", words - w0, 32'd1);
      check("mr_data", 32'(last_obs), 32'h08D);

`ifdef TRUTHTABLE_PACKER_TLAST_EN
      // TLAST flush of a 3-bit partial word
      push(16'h0001, 1'b0, w);
      push(16'h0002, 1'b0, w);
      push(16'h0000, 1'b1, w);
      in_TVALID = 1'b0;
      @(negedge ap_clk);
      check("tl_valid", 32'(out_TVALID), 32'd1);
      check("tl_data", 32'(out_TDATA), 32'h03);
      check("tl_last", 32'(out_TLAST), 32'd1);
      for (int i = 0; i < 8; i++) push(dir[i], 1'b0, w);
      in_TVALID = 1'b0;
      repeat (3) @(negedge ap_clk);
      check("tl_full_word", 32'(last_obs), 32'h08D);
`endif

      // Random valid/ready toggling
      w0 = words;
      fork
         while (!rnd_done) begin
            @(negedge ap_clk);
            if (!rnd_done) out_TREADY = 1'($urandom_range(0, 1));
         end
      join_none
      for (int i = 0; i < 10000; i++) begin
         push(16'($urandom), 1'b0, w);
         if ($urandom_range(0, 3) == 0) begin
            in_TVALID = 1'b0;
            @(negedge ap_clk);
         end
      end
      in_TVALID  = 1'b0;
      rnd_done   = 1'b1;
      out_TREADY = 1'b1;
      repeat (20) @(negedge ap_clk);
      check("rnd_words", words - w0, 32'd1250);
      check("rnd_pending", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
